// File: rtl/shift_pipe_if.sv
// shift_pipe_if: sample/control bundle for shift_pipe; tap_sel exists only with SHIFT_PIPE_TAP_EN
interface shift_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef SHIFT_PIPE_TAP_EN
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [TAP_W-1:0] tap_sel;
`endif
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
`ifdef SHIFT_PIPE_TAP_EN
    modport master (output en, flush, in_valid, in_data, tap_sel, input out_valid, out_data, count);
    modport slave  (input en, flush, in_valid, in_data, tap_sel, output out_valid, out_data, count);
`else
    modport master (output en, flush, in_valid, in_data, input out_valid, out_data, count);
    modport slave  (input en, flush, in_valid, in_data, output out_valid, out_data, count);
`endif
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: stallable DEPTH-stage delay line with valid tracking and occupancy; SHIFT_PIPE_TAP_EN adds a runtime output tap
module shift_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    shift_pipe_if.slave p
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [CNT_W-1:0] cnt;

    // reset and flush clear the line; otherwise shift when enabled, hold when stalled
    always_ff @(posedge clk) begin
        if (!rst_n || p.flush) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
            v   <= '0;
            cnt <= '0;
        end else if (p.en) begin
            data[0] <= p.in_data;
            v[0]    <= p.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
                v[i]    <= v[i-1];
            end
            cnt <= cnt + CNT_W'(p.in_valid) - CNT_W'(v[DEPTH-1]);
        end
    end

`ifdef SHIFT_PIPE_TAP_EN
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [TAP_W-1:0] sel;
    assign sel         = (32'(p.tap_sel) >= DEPTH) ? TAP_W'(DEPTH - 1) : p.tap_sel;
    assign p.out_data  = data[sel];
    assign p.out_valid = v[sel];
`else
    assign p.out_data  = data[DEPTH-1];
    assign p.out_valid = v[DEPTH-1];
`endif
    assign p.count = cnt;
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe (tap checks run when SHIFT_PIPE_TAP_EN is defined)
module tb_shift_pipe;
    localparam int W = 8;
    localparam int D = 4;

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } ent_t;

    logic clk = 0;
    logic rst_n = 0;
    int   passed = 0;
    int   total = 0;
    int   ecnt = 0;
    bit   tap_mode = 0;
    ent_t q[$];

    shift_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
    shift_pipe #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .p(bus));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step(logic e, logic f, logic iv, logic [W-1:0] d);
        bit ev;
        bus.en = e;
        bus.flush = f;
        bus.in_valid = iv;
        bus.in_data = d;
        @(posedge clk);
        if (!rst_n || f) q.delete();
        else if (e) begin
            ecnt++;
            if (q.size() > 0 && q[0].due == ecnt - 1) void'(q.pop_front());
            if (iv) q.push_back('{d, ecnt + D - 1});
        end
        #1;
        ev = q.size() > 0 && q[0].due == ecnt;
        chk("count", 32'(bus.count), q.size());
        if (!tap_mode) begin
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) chk("out_data", 32'(bus.out_data), 32'(q[0].d));
        end
    endtask

    initial begin
`ifdef SHIFT_PIPE_TAP_EN
        bus.tap_sel = D - 1;
`endif
        repeat (2) step(1, 0, 1, 8'hFF);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_count", 32'(bus.count), 0);
        rst_n = 1;
        for (int j = 1; j <= 4; j++) step(1, 0, 1, 8'(j));
        chk("lat_first", 32'(bus.out_data), 32'h01);
        chk("full_count", 32'(bus.count), D);
        for (int j = 0; j < 3; j++) step(0, 0, 1, 8'hE0 + 8'(j));
        chk("stall_data", 32'(bus.out_data), 32'h01);
        chk("stall_count", 32'(bus.count), D);
        for (int j = 5; j <= 6; j++) step(1, 0, 1, 8'(j));
        chk("steady_count", 32'(bus.count), D);
        repeat (D) step(1, 0, 0, 8'h00);
        chk("drain_count", 32'(bus.count), 0);
        step(1, 0, 1, 8'hA1);
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'hA3);
        chk("bubble_peak", 32'(bus.count), 2);
        repeat (D + 1) step(1, 0, 0, 8'h00);
        chk("bubble_empty", 32'(bus.count), 0);
        for (int j = 0; j < D; j++) step(1, 0, 1, 8'hB0 + 8'(j));
        chk("pre_flush", 32'(bus.count), D);
        step(1, 1, 1, 8'h55);
        chk("flush_data", 32'(bus.out_data), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_count", 32'(bus.count), 0);
        repeat (D) step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'hC1);
        step(1, 0, 1, 8'hC2);
        step(0, 1, 1, 8'hC3);
        chk("flush_stall", 32'(bus.count), 0);
        step(1, 0, 1, 8'hD1);
        step(1, 0, 1, 8'hD2);
        rst_n = 0;
        step(1, 0, 1, 8'hD3);
        chk("midrst_count", 32'(bus.count), 0);
        rst_n = 1;
        repeat (D) step(1, 0, 0, 8'h00);
`ifdef SHIFT_PIPE_TAP_EN
        tap_mode = 1;
        for (int j = 0; j < 6; j++) step(1, 0, 1, 8'h40 + 8'(j));
        for (int t = 0; t < D; t++) begin
            bus.tap_sel = t[1:0];
            #1;
            chk("tap_data", 32'(bus.out_data), 32'h45 - t);
            chk("tap_valid", 32'(bus.out_valid), 1);
            chk("tap_count", 32'(bus.count), D);
        end
        bus.tap_sel = D - 1;
        tap_mode = 0;
        repeat (D) step(1, 0, 0, 8'h00);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
